// File: rtl/divmul_ctrl_pkg.sv
// Shared types for the execute-stage multiply/divide sequencer.
// Op encoding, FSM states and op-class helpers used by the top and the divider.
package divmul_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MUL   = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL1,
    S_MUL2,
    S_ACC,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

  function automatic logic is_signed_op(input op_e op);
    return op inside {OP_MULT, OP_DIV, OP_MUL, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic is_div_op(input op_e op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_acc_op(input op_e op);
    return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_sub_op(input op_e op);
    return op inside {OP_MSUB, OP_MSUBU};
  endfunction

endpackage

// File: rtl/divmul_ctrl_div_radix2.sv
// Iterative non-restoring radix-2 divider: one quotient bit per cycle, DIV_ITER cycles after start.
// Outputs are corrected combinationally from the final state; start reloads at any time (no backpressure).
module div_radix2 #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [33:0] p_q;
  logic [31:0] q_q;
  logic [31:0] d_q;
  logic [5:0]  cnt_q;
  logic        busy_q;
  logic        neg_q_q;
  logic        neg_r_q;

  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [33:0] shifted;
  logic [33:0] p_nx;
  logic [31:0] q_nx;
  logic [31:0] rem_abs;

  assign a_abs = (sgn && a[31]) ? -a : a;
  assign b_abs = (sgn && b[31]) ? -b : b;

  // Partial remainder sign (bit 33) picks add or subtract for the next step.
  assign shifted = {p_q[32:0], q_q[31]};
  assign p_nx    = p_q[33] ? shifted + {2'b00, d_q} : shifted - {2'b00, d_q};
  assign q_nx    = {q_q[30:0], ~p_nx[33]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (start) begin
      p_q     <= '0;
      q_q     <= a_abs;
      d_q     <= b_abs;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      neg_q_q <= sgn & (a[31] ^ b[31]);
      neg_r_q <= sgn & a[31];
    end else if (busy_q) begin
      p_q   <= p_nx;
      q_q   <= q_nx;
      cnt_q <= cnt_q + 6'd1;
      if (cnt_q == 6'(DIV_ITER - 1)) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done = busy_q && (cnt_q == 6'(DIV_ITER - 1));

  // A negative final partial remainder still owes one divisor back.
  assign rem_abs   = p_q[33] ? p_q[31:0] + d_q : p_q[31:0];
  assign quotient  = neg_q_q ? -q_q : q_q;
  assign remainder = neg_r_q ? -rem_abs : rem_abs;

endmodule

// File: rtl/divmul_ctrl.sv
// Mul/div sequencer: MUL* done 3 cycles after accept, MADD/MSUB 4, DIV/DIVU DIV_ITER+2.
// Holds the pipeline via stall_req until DONE; DONE persists while stall_in, flush aborts at once.
module divmul_ctrl
  import divmul_ctrl_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  op_e         op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [63:0] hilo_in,
  input  logic        flush,
  input  logic        stall_in,
  output logic        stall_req,
  output logic        done,
  output logic        hilo_we,
  output logic [63:0] hilo_out,
  output logic [31:0] mul_lo
);

  state_e      state_q, state_nx;
  op_e         op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        sgn_q;
  logic [63:0] hilo_q;
  logic        first_q;
  logic [63:0] prod_q;

  logic        accept;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  assign accept = (state_q == S_IDLE) && start && !flush;

  // 33-bit operand extension widened to 64; low 64 bits of the product are all HI/LO needs.
  assign a_ext = {{32{sgn_q & a_q[31]}}, a_q};
  assign b_ext = {{32{sgn_q & b_q[31]}}, b_q};

  div_radix2 #(.DIV_ITER(DIV_ITER)) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (accept && is_div_op(op)),
    .sgn       (is_signed_op(op)),
    .a         (src_a),
    .b         (src_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_nx = is_div_op(op) ? S_DIV : S_MUL1;
      S_MUL1: state_nx = S_MUL2;
      S_MUL2: state_nx = is_acc_op(op_q) ? S_ACC : S_DONE;
      S_ACC:  state_nx = S_DONE;
      S_DIV:  if (div_done) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: if (!stall_in) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hilo_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      first_q <= (state_nx == S_DONE) && (state_q != S_DONE);
      if (accept) begin
        op_q  <= op;
        a_q   <= src_a;
        b_q   <= src_b;
        sgn_q <= is_signed_op(op);
      end
      case (state_q)
        S_MUL2: hilo_q <= prod_q;
        S_ACC:  hilo_q <= is_sub_op(op_q) ? hilo_in - hilo_q : hilo_in + hilo_q;
        S_FIX:  hilo_q <= (b_q == '0) ? {a_q, DIV_BY_ZERO_LO} : {div_rem, div_quo};
        default: ;
      endcase
    end
  end

  // Kept free of reset so the multiply stage maps onto a DSP register.
  always_ff @(posedge clk) begin
    if (state_q == S_MUL1) begin
      prod_q <= a_ext * b_ext;
    end
  end

  assign done      = (state_q == S_DONE);
  assign hilo_we   = done && first_q && (op_q != OP_MUL) && !flush;
  assign stall_req = start && (state_q != S_DONE);
  assign hilo_out  = hilo_q;
  assign mul_lo    = hilo_q[31:0];

endmodule

// File: tb/tb_divmul_ctrl.sv
// Directed bench for divmul_ctrl: arithmetic reference model plus literal result table.
module tb_divmul_ctrl;
  import divmul_ctrl_pkg::*;

  localparam int ITER = 32;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  op_e         op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [63:0] hilo_in;
  logic        flush;
  logic        stall_in;
  logic        stall_req;
  logic        done;
  logic        hilo_we;
  logic [63:0] hilo_out;
  logic [31:0] mul_lo;

  always #5 clk = ~clk;

  divmul_ctrl #(.DIV_ITER(ITER)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .hilo_in   (hilo_in),
    .flush     (flush),
    .stall_in  (stall_in),
    .stall_req (stall_req),
    .done      (done),
    .hilo_we   (hilo_we),
    .hilo_out  (hilo_out),
    .mul_lo    (mul_lo)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic        chk_en  = 1'b0;
  logic        chk_res = 1'b0;
  logic        chk_mul = 1'b0;
  logic        exp_done, exp_we, exp_stall;
  logic [63:0] exp_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [63:0] model(input op_e o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] h);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      OP_MULT, OP_MUL: return sa * sb;
      OP_MULTU:        return ua * ub;
      OP_MADD:         return h + sa * sb;
      OP_MADDU:        return h + ua * ub;
      OP_MSUB:         return h - sa * sb;
      OP_MSUBU:        return h - ua * ub;
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic int lat(input op_e o);
    case (o)
      OP_DIV, OP_DIVU:                       return ITER + 2;
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:  return 4;
      default:                               return 3;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("done", {63'd0, done}, {63'd0, exp_done});
      check("hilo_we", {63'd0, hilo_we}, {63'd0, exp_we});
      check("stall_req", {63'd0, stall_req}, {63'd0, exp_stall});
      if (chk_res) begin
        if (chk_mul) check("mul_lo", {32'd0, mul_lo}, {32'd0, exp_res[31:0]});
        else         check("hilo_out", hilo_out, exp_res);
      end
    end
  end

  // Accept in cycle 0, optional stall_in at DONE, optional flush in cycle flush_at (-1 = none).
  task automatic run_op(input string nm, input op_e o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] h, input int stall_n, input int flush_at,
                        input logic [63:0] lit);
    int          L;
    int          we_cnt;
    int          we_exp;
    logic        post_flush;
    logic        in_done;
    logic [63:0] got;
    L      = lat(o);
    we_cnt = 0;
    got    = '0;
    op      = o;
    src_a   = a;
    src_b   = b;
    hilo_in = h;
    chk_mul = (o == OP_MUL);
    exp_res = model(o, a, b, h);
    for (int c = 0; c <= L + stall_n + 1; c++) begin
      post_flush = (flush_at >= 0) && (c > flush_at);
      in_done    = !post_flush && (c >= L) && (c <= L + stall_n);
      start      = !post_flush && (c <= L + stall_n);
      flush      = (c == flush_at);
      stall_in   = !post_flush && (c >= L) && (c < L + stall_n);
      exp_done   = in_done;
      exp_we     = in_done && (c == L) && (o != OP_MUL) && !flush;
      exp_stall  = start && !in_done;
      chk_res    = in_done;
      chk_en     = 1'b1;
      @(negedge clk);
      if (in_done) got = chk_mul ? {32'd0, mul_lo} : hilo_out;
      if (hilo_we) we_cnt++;
      @(posedge clk);
      #1;
      if (post_flush) break;
    end
    chk_en = 1'b0;
    flush  = 1'b0;
    we_exp = ((o != OP_MUL) && (flush_at < 0 || flush_at > L)) ? 1 : 0;
    check({nm, "_we_count"}, 64'(we_cnt), 64'(we_exp));
    if (flush_at < 0 || flush_at >= L) check({nm, "_literal"}, got, lit);
  endtask

  typedef struct {
    string       nm;
    op_e         o;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] h;
    int          stall_n;
    logic [63:0] lit;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{"mult_neg1x2",  OP_MULT,  32'hFFFF_FFFF, 32'd2,         64'd0,                  0, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[1]  = '{"multu_ffx2",   OP_MULTU, 32'hFFFF_FFFF, 32'd2,         64'd0,                  0, 64'h0000_0001_FFFF_FFFE};
    vecs[2]  = '{"mul_7x6",      OP_MUL,   32'd7,         32'd6,         64'd0,                  0, 64'd42};
    vecs[3]  = '{"madd",         OP_MADD,  32'd3,         32'hFFFF_FFFC, 64'h10,                 0, 64'h0000_0000_0000_0004};
    vecs[4]  = '{"div_m7_2",     OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'd0,                  0, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[5]  = '{"divu_by0",     OP_DIVU,  32'd7,         32'd0,         64'd0,                  0, 64'h0000_0007_FFFF_FFFF};
    vecs[6]  = '{"msubu",        OP_MSUBU, 32'd2,         32'd3,         64'h1_0000_0000,        0, 64'h0000_0000_FFFF_FFFA};
    vecs[7]  = '{"maddu_wrap",   OP_MADDU, 32'd1,         32'd1,         64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0};
    vecs[8]  = '{"msub_neg",     OP_MSUB,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0,                  0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[9]  = '{"div_minint",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'd0,                  0, 64'h0000_0000_8000_0000};
    vecs[10] = '{"div_7_m2",     OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'd0,                  0, 64'h0000_0001_FFFF_FFFD};
    vecs[11] = '{"div_m8_by0",   OP_DIV,   32'hFFFF_FFF8, 32'd0,         64'd0,                  0, 64'hFFFF_FFF8_FFFF_FFFF};
    vecs[12] = '{"mult_stall5",  OP_MULT,  32'h0001_0000, 32'h0001_0000, 64'd0,                  5, 64'h0000_0001_0000_0000};
    vecs[13] = '{"divu_big",     OP_DIVU,  32'hFFFF_FFFF, 32'd10,        64'd0,                  0, 64'h0000_0005_1999_9999};

    resetn   = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    stall_in = 1'b0;
    op       = OP_MULT;
    src_a    = '0;
    src_b    = '0;
    hilo_in  = '0;
    #12;
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo_we", {63'd0, hilo_we}, 64'd0);
    check("rst_stall_req", {63'd0, stall_req}, 64'd0);
    check("rst_hilo_out", hilo_out, 64'd0);
    check("rst_mul_lo", {32'd0, mul_lo}, 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].nm, vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].h, vecs[i].stall_n, -1, vecs[i].lit);
    end

    // DIV aborted in cycle 10; the MULT accepted two cycles later must run normally.
    run_op("div_flush", OP_DIV, 32'd100, 32'd3, 64'd0, 0, 10, 64'd0);
    run_op("mult_after_flush", OP_MULT, 32'd5, 32'hFFFF_FFFD, 64'd0, 0, -1, 64'hFFFF_FFFF_FFFF_FFF1);

    // Flush landing on the done cycle suppresses the write.
    run_op("mult_flush_at_done", OP_MULT, 32'd9, 32'd9, 64'd0, 0, 3, 64'd81);
    run_op("maddu_after", OP_MADDU, 32'd2, 32'd2, 64'd1, 0, -1, 64'd5);

    // Asynchronous reset in the middle of a divide.
    op      = OP_DIVU;
    src_a   = 32'd50;
    src_b   = 32'd7;
    start   = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    start  = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_hilo_we", {63'd0, hilo_we}, 64'd0);
    check("arst_stall_req", {63'd0, stall_req}, 64'd0);
    check("arst_hilo_out", hilo_out, 64'd0);
    check("arst_mul_lo", {32'd0, mul_lo}, 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    run_op("mul_after_rst", OP_MUL, 32'hFFFF_FFFE, 32'd3, 64'd0, 0, -1, 64'h0000_0000_FFFF_FFFA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
